mult_hilo_unit: RTL and testbench

- Iterative shift-add multiplier plus HI/LO register pair in the EX stage of the 5-stage MIPS pipeline.
- Consumes the decoder's Start_mult, Mult_sign and Out_select controls for MULT/MULTU/MFHI/MFLO.
- Computes a 2*WIDTH product over multiple cycles and raises a stall while HI/LO are unavailable.
- Drives the HI or LO value onto the EX result mux for MFHI/MFLO.

---
 rtl/mult_hilo_unit.sv | 106 ++++++++++
 tb/tb_mult_hilo_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - iterative shift-add multiplier with HI/LO pair for the EX stage
// Signed operands are reduced to magnitudes up front; the sign is reapplied once in FIX.
module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_mult,
  input  logic             Mult_sign,
  input  logic [1:0]       Out_select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hilo_out,
  output logic             Busy,
  output logic             Stall,
  output logic             Mult_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_prod;

  // The magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign w_abs_a  = (Mult_sign && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign w_abs_b  = (Mult_sign && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
  assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_count;
  assign w_prod   = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start_mult) w_next = S_RUN;
      S_RUN:   if (r_count == LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start_mult) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= Mult_sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + w_addend;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
        end
        S_FIX: begin
          {r_hi, r_lo} <= w_prod;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (r_state != S_IDLE);
  assign Stall     = Busy & Out_select[1];
  assign Mult_done = r_done;
  assign Hilo_out  = Out_select[0] ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - scoreboard bench for mult_hilo_unit
// Reads (MFHI/MFLO) push their expected value; the monitor pops on each unstalled read.
module tb_mult_hilo_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start_mult = 1'b0;
  logic        Mult_sign = 1'b0;
  logic [1:0]  Out_select = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Hilo_out;
  logic        Busy;
  logic        Stall;
  logic        Mult_done;

  int          total = 0;
  int          bad = 0;
  int          n_done = 0;
  int          n_done_exp = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] q[$];

  mult_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start_mult(Start_mult), .Mult_sign(Mult_sign),
    .Out_select(Out_select), .A(A), .B(B), .Hilo_out(Hilo_out),
    .Busy(Busy), .Stall(Stall), .Mult_done(Mult_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, inputs change just after the rising edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!Out_select[1]) chk("stall_without_hilo", {63'd0, Stall}, 64'd0);
        if (Mult_done) n_done++;
        if (Out_select[1] && !Start_mult && !Stall) begin
          if (q.size() == 0) begin
            chk("unexpected_read", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("hilo_read", {32'd0, Hilo_out}, {32'd0, e});
          end
        end
      end
    end
  end

  task automatic issue(input logic st, input logic sg, input logic [1:0] os,
                       input logic [31:0] a, input logic [31:0] b, output int stalls);
    @(posedge clk); #1;
    Start_mult = st; Mult_sign = sg; Out_select = os; A = a; B = b;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!Stall) break;
      stalls++;
      if (stalls > 200) begin
        chk("issue_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic bubble();
    @(posedge clk); #1;
    Start_mult = 1'b0; Mult_sign = 1'b0; Out_select = 2'b00; A = '0; B = '0;
  endtask

  task automatic mult(input logic sg, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, output int stalls);
    issue(1'b1, sg, 2'b10, a, b, stalls);
    exp_hi = ehi;
    exp_lo = elo;
    n_done_exp++;
  endtask

  task automatic rd(input logic hi, output int stalls);
    q.push_back(hi ? exp_hi : exp_lo);
    issue(1'b0, 1'b0, hi ? 2'b11 : 2'b10, '0, '0, stalls);
  endtask

  task automatic wait_idle(output int busy_cyc);
    bubble();
    busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (!Busy) break;
      busy_cyc++;
      if (busy_cyc > 100) begin
        chk("idle_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic mult_and_read(input logic sg, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ehi, input logic [31:0] elo);
    int s;
    mult(sg, a, b, ehi, elo, s);
    rd(1'b1, s);
    rd(1'b0, s);
  endtask

  initial begin
    int s;
    int bc;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] p;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Mult_done}, 64'd0);
    Out_select = 2'b11; #1;
    chk("reset_stall", {63'd0, Stall}, 64'd0);
    chk("reset_hi", {32'd0, Hilo_out}, 64'd0);
    Out_select = 2'b10; #1;
    chk("reset_lo", {32'd0, Hilo_out}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; Out_select = 2'b00;

    // MULTU max*max: latency and single done pulse
    mult(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, s);
    wait_idle(bc);
    chk("busy_cycles", bc, 64'd33);
    chk("done_first_idle", {63'd0, Mult_done}, 64'd1);
    rd(1'b1, s);
    rd(1'b0, s);

    mult_and_read(1'b1, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1);
    mult_and_read(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001);
    mult_and_read(1'b1, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000);
    mult_and_read(1'b1, 32'h0000_0000, 32'hFFFF_FFF9,  32'h0000_0000, 32'h0000_0000);

    // MFHI right behind MULT stalls for the whole multiply
    mult(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, s);
    rd(1'b1, s);
    chk("mfhi_stall_cycles", s, 64'd33);
    rd(1'b0, s);

    // Back-to-back multiplies: second held by Stall, accepted in the done cycle
    mult(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, s);
    mult(1'b1, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC, s);
    chk("second_mult_stall", s, 64'd33);
    rd(1'b1, s);
    chk("second_mult_busy", s, 64'd33);
    rd(1'b0, s);

    // Reset in the middle of a multiply
    issue(1'b1, 1'b0, 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, s);
    bubble();
    repeat (9) @(posedge clk);
    #1 reset = 1'b1; Out_select = 2'b01;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy", {63'd0, Busy}, 64'd0);
    chk("midreset_stall", {63'd0, Stall}, 64'd0);
    chk("midreset_done", {63'd0, Mult_done}, 64'd0);
    chk("midreset_hi", {32'd0, Hilo_out}, 64'd0);
    Out_select = 2'b00; #1;
    chk("midreset_lo", {32'd0, Hilo_out}, 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    repeat (40) bubble();
    mult_and_read(1'b0, 32'd7, 32'd6, 32'd0, 32'd42);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (rs) p = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      else    p = {32'd0, ra} * {32'd0, rb};
      mult_and_read(rs, ra, rb, p[63:32], p[31:0]);
    end

    repeat (4) bubble();
    chk("queue_empty", q.size(), 64'd0);
    chk("done_pulses", n_done, n_done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
